// File: rtl/db_left_buf_ctrl.sv
// Initiator for the deblocking left-4x4 buffer RAM: arbitrates the single port
// between filter reads and writes, with a one-entry write skid and read forwarding.
module db_left_buf_ctrl #(
    parameter int WORD_WIDTH = 128,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WORD_WIDTH-1:0] wr_data_i,
    input  logic                  rd_valid_i,
    output logic                  rd_ready_o,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic                  rd_data_valid_o,
    output logic [WORD_WIDTH-1:0] rd_data_o,
    output logic                  ram_cen_o,
    output logic                  ram_wen_o,
    output logic                  ram_oen_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [WORD_WIDTH-1:0] ram_data_o,
    input  logic [WORD_WIDTH-1:0] ram_data_i
);

    localparam int ENTRIES = 1 << ADDR_WIDTH;

    typedef enum logic {
        SEL_BYPASS = 1'b0,
        SEL_RAM    = 1'b1
    } rd_sel_t;

    logic [ENTRIES-1:0]    valid_map;
    logic                  skid_valid;
    logic [ADDR_WIDTH-1:0] skid_addr;
    logic [WORD_WIDTH-1:0] skid_data;
    rd_sel_t               rd_sel;
    logic [WORD_WIDTH-1:0] data_hold;

    logic                  rd_accept;
    logic                  wr_accept;
    logic                  rd_written;
    logic                  rd_skid_hit;
    logic                  rd_uses_ram;
    logic                  skid_drain;
    logic                  wr_direct;
    logic                  skid_capture;
    logic [WORD_WIDTH-1:0] bypass_value;

    assign rd_ready_o = rst_n & ~clr_i;
    assign wr_ready_o = rst_n & ~clr_i & ~skid_valid;
    assign rd_accept  = rd_valid_i & rd_ready_o;
    assign wr_accept  = wr_valid_i & wr_ready_o;

    // Reads resolve against start-of-cycle state; a same-cycle write is invisible.
    assign rd_written   = valid_map[rd_addr_i];
    assign rd_skid_hit  = skid_valid & (skid_addr == rd_addr_i);
    assign rd_uses_ram  = rd_accept & rd_written & ~rd_skid_hit;
    assign skid_drain   = rst_n & ~clr_i & skid_valid & ~rd_uses_ram;
    assign wr_direct    = wr_accept & ~rd_uses_ram & ~skid_valid;
    assign skid_capture = wr_accept & rd_uses_ram;
    assign bypass_value = rd_written ? skid_data : '0;

    always_comb begin
        ram_cen_o  = 1'b1;
        ram_wen_o  = 1'b1;
        ram_oen_o  = 1'b0;
        ram_addr_o = '0;
        ram_data_o = '0;
        if (rd_uses_ram) begin
            ram_cen_o  = 1'b0;
            ram_addr_o = rd_addr_i;
        end else if (skid_drain) begin
            ram_cen_o  = 1'b0;
            ram_wen_o  = 1'b0;
            ram_addr_o = skid_addr;
            ram_data_o = skid_data;
        end else if (wr_direct) begin
            ram_cen_o  = 1'b0;
            ram_wen_o  = 1'b0;
            ram_addr_o = wr_addr_i;
            ram_data_o = wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_map  <= '0;
            skid_valid <= 1'b0;
            skid_addr  <= '0;
            skid_data  <= '0;
        end else if (clr_i) begin
            valid_map  <= '0;
            skid_valid <= 1'b0;
        end else begin
            if (wr_accept) begin
                valid_map[wr_addr_i] <= 1'b1;
            end
            if (skid_capture) begin
                skid_valid <= 1'b1;
                skid_addr  <= wr_addr_i;
                skid_data  <= wr_data_i;
            end else if (skid_drain) begin
                skid_valid <= 1'b0;
            end
        end
    end

    // data_hold doubles as the bypass register and the held copy of the last result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_valid_o <= 1'b0;
            rd_sel          <= SEL_BYPASS;
            data_hold       <= '0;
        end else begin
            rd_data_valid_o <= rd_accept;
            if (rd_accept) begin
                rd_sel <= rd_uses_ram ? SEL_RAM : SEL_BYPASS;
            end
            if (rd_accept && !rd_uses_ram) begin
                data_hold <= bypass_value;
            end else if (rd_data_valid_o && rd_sel == SEL_RAM) begin
                data_hold <= ram_data_i;
            end
        end
    end

    assign rd_data_o = (rd_data_valid_o && rd_sel == SEL_RAM) ? ram_data_i : data_hold;

endmodule

// File: tb/tb_db_left_buf_ctrl.sv
// Self-checking bench for db_left_buf_ctrl: directed scenarios plus random traffic
// compared against a logical-content model, with a behavioural single-port RAM.
module tb_db_left_buf_ctrl;

    localparam int W = 128;
    localparam int A = 3;

    logic         clk;
    logic         rst_n;
    logic         clr_i;
    logic         wr_valid_i;
    logic         wr_ready_o;
    logic [A-1:0] wr_addr_i;
    logic [W-1:0] wr_data_i;
    logic         rd_valid_i;
    logic         rd_ready_o;
    logic [A-1:0] rd_addr_i;
    logic         rd_data_valid_o;
    logic [W-1:0] rd_data_o;
    logic         ram_cen_o;
    logic         ram_wen_o;
    logic         ram_oen_o;
    logic [A-1:0] ram_addr_o;
    logic [W-1:0] ram_data_o;
    logic [W-1:0] ram_data_i;

    db_left_buf_ctrl #(.WORD_WIDTH(W), .ADDR_WIDTH(A)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .clr_i           (clr_i),
        .wr_valid_i      (wr_valid_i),
        .wr_ready_o      (wr_ready_o),
        .wr_addr_i       (wr_addr_i),
        .wr_data_i       (wr_data_i),
        .rd_valid_i      (rd_valid_i),
        .rd_ready_o      (rd_ready_o),
        .rd_addr_i       (rd_addr_i),
        .rd_data_valid_o (rd_data_valid_o),
        .rd_data_o       (rd_data_o),
        .ram_cen_o       (ram_cen_o),
        .ram_wen_o       (ram_wen_o),
        .ram_oen_o       (ram_oen_o),
        .ram_addr_o      (ram_addr_o),
        .ram_data_o      (ram_data_o),
        .ram_data_i      (ram_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: read data appears one cycle after the access and then holds.
    logic [W-1:0] ram_mem [8];
    always @(posedge clk) begin
        if (!ram_cen_o) begin
            if (!ram_wen_o) ram_mem[ram_addr_o] <= ram_data_o;
            else            ram_data_i <= ram_mem[ram_addr_o];
        end
    end

    int total = 0;
    int bad   = 0;

    // Model: what the filter has stored since the last clear, and what is waiting for the port.
    logic [W-1:0] logical [8];
    logic [7:0]   written;
    logic         pend;
    logic [A-1:0] pend_addr;
    logic         exp_rvalid;
    logic [W-1:0] exp_rdata;

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 8; i++) logical[i] = '0;
        written    = '0;
        pend       = 1'b0;
        pend_addr  = '0;
        exp_rvalid = 1'b0;
        exp_rdata  = '0;
    endtask

    // One clock cycle: drive, check every output against the model, then advance the model.
    task automatic applyStimulus(input logic rst, input logic clr,
                                 input logic wv, input logic [A-1:0] wa, input logic [W-1:0] wd,
                                 input logic rv, input logic [A-1:0] ra);
        logic         e_rrdy, e_wrdy, racc, wacc, rd_port, drain, wdir;
        logic         e_cen, e_wen;
        logic [A-1:0] e_addr;
        logic [W-1:0] e_data, rd_result;
        @(negedge clk);
        rst_n = rst; clr_i = clr;
        wr_valid_i = wv; wr_addr_i = wa; wr_data_i = wd;
        rd_valid_i = rv; rd_addr_i = ra;
        #1;
        e_rrdy  = rst & ~clr;
        e_wrdy  = rst & ~clr & ~pend;
        racc    = rv & e_rrdy;
        wacc    = wv & e_wrdy;
        rd_port = racc & written[ra] & ~(pend && pend_addr == ra);
        drain   = rst & ~clr & pend & ~rd_port;
        wdir    = wacc & ~rd_port & ~pend;
        rd_result = written[ra] ? logical[ra] : '0;
        e_cen = 1'b1; e_wen = 1'b1; e_addr = '0; e_data = '0;
        if (rd_port) begin
            e_cen = 1'b0; e_addr = ra;
        end else if (drain) begin
            e_cen = 1'b0; e_wen = 1'b0; e_addr = pend_addr; e_data = logical[pend_addr];
        end else if (wdir) begin
            e_cen = 1'b0; e_wen = 1'b0; e_addr = wa; e_data = wd;
        end
        checkOutput("rd_ready", W'(rd_ready_o), W'(e_rrdy));
        checkOutput("wr_ready", W'(wr_ready_o), W'(e_wrdy));
        checkOutput("rd_data_valid", W'(rd_data_valid_o), W'(exp_rvalid));
        checkOutput("rd_data", rd_data_o, exp_rdata);
        checkOutput("ram_cen", W'(ram_cen_o), W'(e_cen));
        checkOutput("ram_wen", W'(ram_wen_o), W'(e_wen));
        checkOutput("ram_oen", W'(ram_oen_o), W'(1'b0));
        checkOutput("ram_addr", W'(ram_addr_o), W'(e_addr));
        if (e_cen || !e_wen) checkOutput("ram_data", ram_data_o, e_data);
        if (!rst) begin
            modelReset();
        end else if (clr) begin
            written    = '0;
            pend       = 1'b0;
            exp_rvalid = 1'b0;
        end else begin
            exp_rvalid = racc;
            if (racc) exp_rdata = rd_result;
            if (drain) pend = 1'b0;
            if (wacc) begin
                logical[wa] = wd;
                written[wa] = 1'b1;
                if (rd_port) begin
                    pend      = 1'b1;
                    pend_addr = wa;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, '0, 0, 0);
    endtask

    function automatic logic [W-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [W-1:0] pat_a5;
        logic [W-1:0] pat_11;
        pat_a5 = {16{8'hA5}};
        pat_11 = {32{4'h1}};
        for (int i = 0; i < 8; i++) ram_mem[i] = '0;
        ram_data_i = '0;
        rst_n = 0; clr_i = 0; wr_valid_i = 0; wr_addr_i = 0; wr_data_i = '0;
        rd_valid_i = 0; rd_addr_i = 0;
        modelReset();
        repeat (2) @(posedge clk);

        // Reset state, then a read of an unwritten entry returns zero without touching the RAM
        applyStimulus(0, 0, 1, 1, rnd128(), 1, 1);
        applyStimulus(1, 0, 0, 0, '0, 1, 5);
        idle(1);

        // Direct write then RAM read
        applyStimulus(1, 0, 1, 2, pat_a5, 0, 0);
        applyStimulus(1, 0, 0, 0, '0, 1, 2);
        idle(1);

        // Write collides with a RAM read: skid capture, drain, ready again
        applyStimulus(1, 0, 1, 3, pat_11, 1, 2);
        applyStimulus(1, 0, 1, 4, rnd128(), 0, 0);
        idle(2);

        // Forwarding from a full skid
        applyStimulus(1, 0, 1, 3, pat_11, 1, 2);
        applyStimulus(1, 0, 0, 0, '0, 1, 3);
        idle(2);

        // Fill all entries then stream reads back-to-back
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 1, A'(i), rnd128(), 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, '0, 1, A'(i));
        idle(2);

        // Clear with a full skid: nothing accepted, skid discarded, reads return zero
        applyStimulus(1, 0, 1, 6, rnd128(), 1, 0);
        applyStimulus(1, 1, 1, 7, rnd128(), 1, 1);
        for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, '0, 1, A'(i));
        idle(2);

        // Random traffic with occasional clears and resets
        for (int n = 0; n < 4000; n++) begin
            applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 59) == 0),
                          $urandom_range(0, 1) == 1, A'($urandom_range(0, 7)), rnd128(),
                          $urandom_range(0, 2) != 0, A'($urandom_range(0, 7)));
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/db_left_buf_ctrl.md
Name: db_left_buf_ctrl

Overview:
Access controller that acts as the initiator on the deblocking left-4x4 buffer's single-port RAM (128-bit x 8, active-low cen/wen/oen).
- Write side: the deblocking filter stores the filtered right-column 4x4 blocks of the current MB.
- Read side: the same filter fetches them back as left-neighbour data for the next MB.
- The controller arbitrates the one RAM port between the two sides, buffers a blocked write, forwards pending write data, and returns zero for entries not yet written since the last clear.

Parameters:
WORD_WIDTH  128  RAM word width, one 4x4 block of 8-bit pixels
ADDR_WIDTH  3    RAM address width (8 entries)

Ports:
clk              in   1           clock
rst_n            in   1           synchronous reset, active low
clr_i            in   1           clear valid bitmap and pending write (new MB row / frame start)
wr_valid_i       in   1           write request
wr_ready_o       out  1           write accepted when valid&ready
wr_addr_i        in   ADDR_WIDTH  write entry
wr_data_i        in   WORD_WIDTH  write data
rd_valid_i       in   1           read request
rd_ready_o       out  1           read accepted when valid&ready
rd_addr_i        in   ADDR_WIDTH  read entry
rd_data_valid_o  out  1           rd_data_o valid this cycle
rd_data_o        out  WORD_WIDTH  read data
ram_cen_o        out  1           RAM chip enable, low active
ram_wen_o        out  1           RAM write enable, low active
ram_oen_o        out  1           RAM output enable, low active
ram_addr_o       out  ADDR_WIDTH  RAM address
ram_data_o       out  WORD_WIDTH  RAM write data
ram_data_i       in   WORD_WIDTH  RAM read data (valid 1 cycle after read access)

Behaviour:
- Reset (rst_n=0 at posedge): valid bitmap=0, skid empty, rd_data_valid_o=0, rd_data_o=0.
- Combinational outputs during reset: wr_ready_o=0, rd_ready_o=0.
- State: 8-bit valid bitmap; 1-entry write skid (valid, addr, data); read-return select (RAM / bypass); bypass data register.
- Handshake outputs: rd_ready_o = !clr_i; wr_ready_o = !clr_i & !skid_valid.
- The RAM port drives are combinational from the current cycle's decision. ram_oen_o is tied to 0. When idle: cen=1, wen=1, addr=0, data=0.
- Port priority each cycle:
  1. An accepted read uses the port, but only if its bitmap bit is 1 and it does not hit the skid.
  2. Otherwise, skid_valid drains the skid to RAM (cen=0, wen=0).
  3. Otherwise, an accepted write goes directly to RAM.
- Accepted write while the port is used by a read: the write is captured into the skid (skid was empty, guaranteed by wr_ready_o).
- Skid drains on the first cycle with no RAM read; skid_valid clears the next cycle.
- Bitmap bit for wr_addr_i is set on write acceptance, not on RAM commit.
- Read resolution uses the state at the start of the cycle; a same-cycle accepted write is NOT visible to that read (returns old data). In order:
  1. Bitmap bit=0: return 0, no RAM access.
  2. skid_valid & rd_addr_i==skid addr: return skid data (forward), no RAM access.
  3. Else: RAM read (cen=0, wen=1, addr=rd_addr_i), select=RAM.
- Read latency is exactly 1 cycle: rd_data_valid_o=1 in the cycle after acceptance.
  - rd_data_o = ram_data_i when select=RAM, else the bypass register (zero or forwarded data).
  - rd_data_o holds its last value while rd_data_valid_o=0.
  - Back-to-back reads: one result per cycle, no bubbles.
- clr_i (highest priority after reset):
  - clears the bitmap and discards the skid;
  - no requests are accepted and the RAM is idle that cycle;
  - a read accepted in the previous cycle still returns on schedule.
- Write throughput: an unbroken stream of reads plus writes stalls writes after one skid capture, until a read-free cycle.
- Reset mid-operation: in-flight read return is dropped (rd_data_valid_o=0); the skid is lost.

Test Plan:
1. Reset, then read addr 5 → 1 cycle later rd_data_valid_o=1, rd_data_o=0; ram_cen_o stays 1 throughout.
2. Write addr 2 = 128'hA5..A5 (no read) → same cycle cen=0, wen=0, addr=2. Read addr 2 next cycle → cen=0, wen=1; data A5..A5 returned 1 cycle later.
3. Same cycle: write addr 3 = 128'h1111.. and read addr 2 (valid) → RAM reads 2 and the write goes to the skid.
   - Next cycle: wr_ready_o=0 and the skid is committed (cen=0, wen=0, addr=3).
   - The following cycle: wr_ready_o=1.
4. Skid holds addr 3 = 128'h1111.. while a read of addr 3 arrives → no RAM access; returns 1111.. 1 cycle later via forwarding.
5. Reads every cycle of addrs 0..7 after writing all 8 entries → 8 consecutive rd_data_valid_o pulses with matching data, in order.
6. Assert clr_i with the skid full → wr_ready_o=0 and rd_ready_o=0; the skid is never committed; a subsequent read of any addr returns 0.
